cache_controller: RTL
=====================

// Module: cache_controller
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate L1 data cache controller between the CPU data port and main_memory.
//  Serves read hits in zero wait cycles and fills 4-word blocks from main_memory's 128-bit read port on a miss.
//  Forwards every store to main_memory one word at a time and stalls the CPU until the memory acknowledges.
// PARAMETERS
//  add_width   10    word-address width (tag 3 | index 5 | offset 2)
//  data_width  32    CPU word width; block = 4*data_width
//  num_lines   32    cache lines (index width = log2(num_lines) = 5)
// PORTS
//  clk                input   1    system clock, all state updates on posedge
//  rst                input   1    synchronous, active-high reset
//  cpu_add            input   10   CPU word address
//  cpu_write_data     input   32   store data
//  cpu_read           input   1    load request, held until cpu_stall low
//  cpu_write          input   1    store request, held until cpu_stall low
//  cpu_read_data      output  32   load data, valid when cpu_read=1 and cpu_stall=0
//  cpu_stall          output  1    CPU must hold its request/pipeline
//  mem_add            output  10   address to main_memory
//  mem_write_data     output  32   store data to main_memory
//  mem_read           output  1    block read request (registered)
//  mem_write          output  1    word write request (registered)
//  mem_read_data      input   128  block from main_memory, word k at [32k+31:32k]
//  mem_ready_to_read  input   1    main_memory block-read acknowledge
//  mem_finished_writing input 1    main_memory write acknowledge
// BEHAVIOUR
//  Address split: offset=cpu_add[1:0], index=cpu_add[6:2], tag=cpu_add[9:7]; line = valid, tag[2:0], 128-bit data.
//  hit = valid[index] && tag_ram[index]==tag (combinational).
//  States: IDLE, FILL, WRITE, WDONE. Reset -> IDLE; all valid bits cleared; mem_read=0, mem_write=0, mem_add=0, mem_write_data=0.
//  IDLE: cpu_write -> latch mem_add=cpu_add, mem_write_data=cpu_write_data, mem_write=1; on hit update data word[offset]
//    in the same edge; -> WRITE. Else cpu_read && !hit -> mem_add={cpu_add[9:2],2'b00}, mem_read=1, -> FILL.
//    Else (read hit or no request) stay IDLE.
//  cpu_read and cpu_write both high: treated as a store; the load is served after the store completes.
//  FILL: mem_read held, mem_add stable. When ack is valid: capture mem_read_data into line, set valid, write tag,
//    drop mem_read, -> IDLE; the held cpu_read then hits the next cycle.
//  WRITE: mem_write and data held. When ack is valid: drop mem_write, -> WDONE.
//  WDONE: cpu_stall=0 for exactly one cycle (store retires); the request is not re-executed; -> IDLE.
//  Ack validity: main_memory's ready/finished flags are registered and sticky from the previous access, and its
//    2-bit counter is not reset. mem_ready_to_read / mem_finished_writing are therefore ignored during the first cycle
//    of FILL/WRITE (a 1-bit req_age flag) and accepted from the second cycle on. Memory latency is 1..4+ cycles;
//    no fixed latency is assumed.
//  cpu_stall (combinational) = (IDLE & (cpu_write | (cpu_read & !hit))) | FILL | WRITE.
//  cpu_read_data = selected word of the hit line (mux on offset); 0 when no hit.
//  Repeated writes of the same word while mem_write is held are idempotent in main_memory and permitted.
//  rst mid-FILL or mid-WRITE: -> IDLE next edge, mem_read/mem_write low, valid cleared, partial fill discarded.
//    A store interrupted by rst is not guaranteed to have reached memory.
//  Write miss: no allocation; the cache is unchanged.
// TESTING
//  1 Reset, then cpu_read add=0x045 -> stall high, mem_read=1 mem_add=0x044; after ack, line 17 is valid with tag 0 and
//    the next cycle returns mem word 0x045 with stall=0.
//  2 Read 0x046 after test 1 -> hit in the same cycle, stall=0, no mem_read pulse.
//  3 Store 0xDEADBEEF to 0x045 (hit) -> mem_write held until finished; WDONE stall=0 for 1 cycle; reload 0x045 hits
//    and returns 0xDEADBEEF; memory word 0x045 = 0xDEADBEEF.
//  4 Store to 0x3C0 (miss, line 16 invalid) -> memory updated; following load of 0x3C0 misses and fills.
//  5 Load 0x085, then 0x185 (same index 1, tags 1/3) -> second load evicts the first; reload of 0x085 misses again.
//  6 Assert rst two cycles into a FILL -> next cycle IDLE, mem_read=0, all lines invalid; stale mem_ready_to_read=1 on the
//    first FILL cycle is ignored, checked by forcing it high.

Source files
------------

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Read hits return in the same cycle; misses fill a 4-word block, stores go word-by-word to memory.
module cache_controller #(
  parameter int add_width  = 10,
  parameter int data_width = 32,
  parameter int num_lines  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [add_width-1:0]    cpu_add,
  input  logic [data_width-1:0]   cpu_write_data,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  output logic [data_width-1:0]   cpu_read_data,
  output logic                    cpu_stall,
  output logic [add_width-1:0]    mem_add,
  output logic [data_width-1:0]   mem_write_data,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [4*data_width-1:0] mem_read_data,
  input  logic                    mem_ready_to_read,
  input  logic                    mem_finished_writing
);

  localparam int index_width = $clog2(num_lines);
  localparam int tag_width   = add_width - index_width - 2;
  localparam int block_width = 4 * data_width;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t                 state_reg, state_next;
  logic                   req_age_reg;
  logic                   mem_read_reg, mem_write_reg;
  logic [add_width-1:0]   mem_add_reg;
  logic [data_width-1:0]  mem_write_data_reg;
  logic [num_lines-1:0]   valid_reg;
  logic [tag_width-1:0]   tag_ram  [num_lines];
  logic [block_width-1:0] data_ram [num_lines];

  logic [1:0]             offset;
  logic [index_width-1:0] index, fill_index;
  logic [tag_width-1:0]   tag, fill_tag;
  logic [block_width-1:0] line_data;
  logic [data_width-1:0]  line_words [4];
  logic                   hit, read_miss;
  logic                   start_write, start_fill, fill_done, write_done;

  assign offset     = cpu_add[1:0];
  assign index      = cpu_add[index_width+1:2];
  assign tag        = cpu_add[add_width-1:index_width+2];
  assign fill_index = mem_add_reg[index_width+1:2];
  assign fill_tag   = mem_add_reg[add_width-1:index_width+2];

  assign line_data = data_ram[index];
  assign hit       = valid_reg[index] && (tag_ram[index] == tag);
  assign read_miss = cpu_read && !hit;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign line_words[gi] = line_data[gi*data_width +: data_width];
    end
  endgenerate

  assign cpu_read_data = hit ? line_words[offset] : '0;

  // A store takes priority over a simultaneous load; the load is served once the store retires.
  assign start_write = (state_reg == IDLE) && cpu_write;
  assign start_fill  = (state_reg == IDLE) && !cpu_write && read_miss;
  // Memory flags are sticky from the previous access, so they only count from the second request cycle.
  assign fill_done   = (state_reg == FILL)  && req_age_reg && mem_ready_to_read;
  assign write_done  = (state_reg == WRITE) && req_age_reg && mem_finished_writing;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_write) begin
          state_next = WRITE;
        end else if (read_miss) begin
          state_next = FILL;
        end
      end
      FILL:    if (fill_done)  state_next = IDLE;
      WRITE:   if (write_done) state_next = WDONE;
      WDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    case (state_reg)
      IDLE:        cpu_stall = cpu_write || read_miss;
      FILL, WRITE: cpu_stall = 1'b1;
      default:     cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_age_reg        <= 1'b0;
      mem_read_reg       <= 1'b0;
      mem_write_reg      <= 1'b0;
      mem_add_reg        <= '0;
      mem_write_data_reg <= '0;
      valid_reg          <= '0;
    end else begin
      req_age_reg <= (state_reg == FILL) || (state_reg == WRITE);
      if (start_write) begin
        mem_add_reg        <= cpu_add;
        mem_write_data_reg <= cpu_write_data;
        mem_write_reg      <= 1'b1;
      end else if (start_fill) begin
        mem_add_reg  <= {cpu_add[add_width-1:2], 2'b00};
        mem_read_reg <= 1'b1;
      end
      if (fill_done) begin
        mem_read_reg          <= 1'b0;
        valid_reg[fill_index] <= 1'b1;
      end
      if (write_done) begin
        mem_write_reg <= 1'b0;
      end
    end
  end

  // Line storage has no reset; validity alone decides whether contents are used.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        data_ram[fill_index] <= mem_read_data;
        tag_ram[fill_index]  <= fill_tag;
      end else if (start_write && hit) begin
        data_ram[index][offset*data_width +: data_width] <= cpu_write_data;
      end
    end
  end

  assign mem_read       = mem_read_reg;
  assign mem_write      = mem_write_reg;
  assign mem_add        = mem_add_reg;
  assign mem_write_data = mem_write_data_reg;

endmodule
